him_scheduler: RTL and testbench
================================

# him_scheduler

Event-level sequencer and arbiter for the hit info memory (HIM) block. It shares the HIM write path between NREQ hit streams using round-robin arbitration and keeps a per-row hit-count table that supplies the HIM's `nOldHits`. It orders each event through clear, fill, drain and readout phases, and serves one readout requester that receives the packed hit word and hit count per row.

## Interface
- `NREQ`, 4, number of hit-stream requesters
- `ROWBITS`, 10, HIM row index width (NROWS = 2**ROWBITS)
- `HITBITS`, 16, width of one hit info word
- `MAXHITNBITS`, 3, hit-count width; row capacity MAXHITS = 2**MAXHITNBITS-1
- `DRAIN_CYCLES`, 6, wait after last write before readout (≥ BRAM_READDELAY+3)
- `clk` in 1, clock
- `reset` in 1, synchronous, active-high
- `hit_valid` in NREQ, per-requester hit offered
- `hit_ready` out NREQ, per-requester grant (one-hot or zero)
- `hit_row` in NREQ*ROWBITS, packed row per requester
- `hit_info` in NREQ*HITBITS, packed hit per requester
- `event_end` in 1, pulse: no more hits this event
- `event_clear` in 1, pulse: start next event
- `him_write_row` out 1, HIM writeRow strobe
- `him_row_to_write` out ROWBITS
- `him_hit_info` out HITBITS*MAXHITS, new hit in bits [HITBITS-1:0], rest 0
- `him_n_old_hits` out MAXHITNBITS
- `him_n_new_hits` out MAXHITNBITS, always 1 when writing
- `him_read_row` out 1, HIM readRow strobe
- `him_row_to_read` out ROWBITS
- `him_read_finished` in 1
- `him_hit_info_read` in HITBITS*MAXHITS
- `rd_valid` in 1, `rd_ready` out 1, `rd_row` in ROWBITS, readout request handshake
- `rd_data_valid` out 1, `rd_data` out HITBITS*MAXHITS, `rd_nhits` out MAXHITNBITS, readout result (one-cycle pulse)
- `overflow_count` out 16, saturating dropped-hit counter
- `phase` out 2, current state encoding

## Operation
- States: CLEAR(0), FILL(1), DRAIN(2), READ(3).
- CLEAR: row counter sweeps 0..NROWS-1, writing 0 to the count table, one row per cycle. Moves to FILL after row NROWS-1. All ready outputs are 0.
- FILL: round-robin grant among asserted `hit_valid`. The priority pointer starts one past the last granted requester. `hit_ready[g]` is combinational; a handshake is `hit_valid[g]&hit_ready[g]`.
- On a handshake with count c = table[row]:
  - if c < MAXHITS: issue a HIM write (row, hit, n_old=c, n_new=1) and set table[row] = c+1.
  - if c == MAXHITS: drop the hit and increment `overflow_count` (saturates at 0xFFFF).
- `event_end` in FILL moves the block to DRAIN; a hit handshaking in the same cycle is still accepted. `event_end` in any other state is ignored.
- DRAIN: wait DRAIN_CYCLES, then move to READ.
- READ: `rd_ready` = 1 while no readout is outstanding. On a handshake:
  - if table[row] == 0: return `rd_data` = 0 and `rd_nhits` = 0 without a HIM read.
  - otherwise pulse `him_read_row` and wait for `him_read_finished`, then return `him_hit_info_read` with `rd_nhits` = table[row].
- `event_clear` in READ moves to CLEAR once no readout is outstanding. If a readout is outstanding, the clear is held pending until that readout completes. `event_clear` in other states is ignored.
- `overflow_count` is cleared on entry to CLEAR.

## Timing
- Reset: state CLEAR, sweep row counter 0, RR pointer 0, all strobes/valids 0, data outputs 0, `overflow_count` 0, `phase` 0. Reset mid-event aborts all activity; the next event starts after a full NROWS-cycle sweep.
- HIM command outputs are registered: a strobe asserts the cycle after the handshake and lasts exactly one cycle.
- The count-table update is visible on the next cycle. Back-to-back hits to the same row therefore get n_old = 0, 1, 2, …
- At most one HIM command is issued per cycle, and writes and reads never coincide (they occur in different phases).
- Readout with a HIM read:
  - handshake at cycle t, `him_read_row` at t+1.
  - `rd_data_valid` the cycle after `him_read_finished`.
  - `rd_ready` is low from t+1 until the cycle after `rd_data_valid`.
- Readout with zero hits: `rd_data_valid` at t+1.

## Configuration
- `HIM_SCHED_OVERFLOW_CNT_EN`: defined → counter implemented as described. Undefined → `overflow_count` tied to 0 and no counter logic; hits to full rows are still dropped.

## Structure
- Shared package `him_sched_pkg`: state enum (CLEAR/FILL/DRAIN/READ), MAXHITS constant, and the packed-hit helper type.
- Sub-module `rr_arbiter` (NREQ-wide round-robin, combinational grant, pointer registered on handshake).
- The count table stays in this block as NROWS×MAXHITNBITS distributed RAM with combinational read.

## Test plan
- Reset, idle: `phase` holds 0 for 1024 cycles, then 1; all ready outputs are 0 during the sweep.
- Requesters 0 and 2 hold valid on rows 5 and 9: grants alternate 0,2,0,2; row 5 writes show n_old 0,1,2.
- Eight hits to row 3 with MAXHITS=7: seven writes (n_old 0..6); the eighth is dropped; `overflow_count` = 1.
- `event_end`, then readout of row 3: `him_read_row` fires at least DRAIN_CYCLES after `event_end`. Returns HIM data with `rd_nhits` = 7; readout of row 4 returns `rd_nhits` = 0 at t+1 with no HIM read.
- `event_clear` while a readout is outstanding: the result is delivered first, then CLEAR is entered, `overflow_count` returns to 0, and a re-read in the next event shows `rd_nhits` = 0.
- Reset asserted mid-FILL: strobes drop next cycle, `phase` = 0, and the old row counts read as 0 in the next event.

Source files
------------

// File: rtl/him_sched_pkg.sv
// rtl/him_sched_pkg.sv - shared phase encoding, row-capacity constant and hit-word type for him_scheduler
package him_sched_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_READ  = 2'd3
   } sched_state_t;

   localparam int HITBITS_DFLT     = 16;
   localparam int MAXHITNBITS_DFLT = 3;
   localparam int MAXHITS          = (1 << MAXHITNBITS_DFLT) - 1;

   // One HIM row worth of hits at the default widths
   typedef logic [HITBITS_DFLT*MAXHITS-1:0] him_row_word_t;

   function automatic int max_hits(input int nbits);
      return (1 << nbits) - 1;
   endfunction

endpackage

// File: rtl/him_scheduler_rr_arbiter.sv
// rtl/him_scheduler_rr_arbiter.sv - N-way round-robin arbiter, combinational grant
// Priority starts one past the last winner; the pointer only moves on a grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      grant = '0;
      win   = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (found)
         ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
   end

endmodule

// File: rtl/him_scheduler.sv
// rtl/him_scheduler.sv - HIM event sequencer: clear/fill/drain/read phases, hit arbitration, row hit counts
// Optional feature: define HIM_SCHED_OVERFLOW_CNT_EN for the saturating dropped-hit counter.
module him_scheduler
   import him_sched_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int ROWBITS      = 10,
   parameter int HITBITS      = HITBITS_DFLT,
   parameter int MAXHITNBITS  = MAXHITNBITS_DFLT,
   parameter int DRAIN_CYCLES = 6
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NREQ-1:0]                                hit_valid,
   output logic [NREQ-1:0]                                hit_ready,
   input  logic [NREQ*ROWBITS-1:0]                        hit_row,
   input  logic [NREQ*HITBITS-1:0]                        hit_info,
   input  logic                                           event_end,
   input  logic                                           event_clear,
   output logic                                           him_write_row,
   output logic [ROWBITS-1:0]                             him_row_to_write,
   output logic [HITBITS*((1<<MAXHITNBITS)-1)-1:0]        him_hit_info,
   output logic [MAXHITNBITS-1:0]                         him_n_old_hits,
   output logic [MAXHITNBITS-1:0]                         him_n_new_hits,
   output logic                                           him_read_row,
   output logic [ROWBITS-1:0]                             him_row_to_read,
   input  logic                                           him_read_finished,
   input  logic [HITBITS*((1<<MAXHITNBITS)-1)-1:0]        him_hit_info_read,
   input  logic                                           rd_valid,
   output logic                                           rd_ready,
   input  logic [ROWBITS-1:0]                             rd_row,
   output logic                                           rd_data_valid,
   output logic [HITBITS*((1<<MAXHITNBITS)-1)-1:0]        rd_data,
   output logic [MAXHITNBITS-1:0]                         rd_nhits,
   output logic [15:0]                                    overflow_count,
   output logic [1:0]                                     phase
);
   localparam int NROWS   = 2**ROWBITS;
   localparam int ROW_CAP = max_hits(MAXHITNBITS);
   localparam int DW      = $clog2(DRAIN_CYCLES + 1);
   localparam int SW      = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_t           state, state_nx;
   logic [ROWBITS-1:0]     sweep_row;
   logic [DW-1:0]          drain_cnt;
   logic [MAXHITNBITS-1:0] cnt_table [NROWS];
   logic [NREQ-1:0]        grant;
   logic [SW-1:0]          sel;
   logic [ROWBITS-1:0]     sel_row;
   logic [HITBITS-1:0]     sel_hit;
   logic [MAXHITNBITS-1:0] sel_cnt, rd_cnt, rd_nhits_pend;
   logic                   hit_hs, hit_wr, rd_hs;
   logic                   rd_busy, him_wait, clear_pend, go_clear;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (state == ST_FILL),
      .req   (hit_valid),
      .grant (grant)
   );

   always_comb begin
      sel = '0;
      for (int i = 0; i < NREQ; i++)
         if (grant[i]) sel = SW'(i);
   end

   assign sel_row = hit_row[int'(sel)*ROWBITS +: ROWBITS];
   assign sel_hit = hit_info[int'(sel)*HITBITS +: HITBITS];
   assign sel_cnt = cnt_table[sel_row];
   assign rd_cnt  = cnt_table[rd_row];
   assign hit_hs  = |(hit_valid & grant);
   assign hit_wr  = hit_hs && (sel_cnt != MAXHITNBITS'(ROW_CAP));
   assign rd_hs   = rd_valid && rd_ready;
   // A pending clear may leave READ in the very cycle the outstanding result is delivered
   assign go_clear = (state == ST_READ) && (event_clear || clear_pend) && (!rd_busy || rd_data_valid);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_CLEAR;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_CLEAR: if (sweep_row == '1) state_nx = ST_FILL;
         ST_FILL:  if (event_end) state_nx = ST_DRAIN;
         ST_DRAIN: if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_nx = ST_READ;
         ST_READ:  if (go_clear) state_nx = ST_CLEAR;
      endcase
   end

   always_comb begin
      hit_ready = grant;
      rd_ready  = (state == ST_READ) && !rd_busy && !clear_pend && !event_clear;
      phase     = state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sweep_row <= '0;
         drain_cnt <= '0;
      end else begin
         sweep_row <= (state == ST_CLEAR) ? sweep_row + ROWBITS'(1) : sweep_row;
         drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_CLEAR)
         cnt_table[sweep_row] <= '0;
      else if (!reset && hit_wr)
         cnt_table[sel_row] <= sel_cnt + MAXHITNBITS'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         him_write_row    <= 1'b0;
         him_row_to_write <= '0;
         him_hit_info     <= '0;
         him_n_old_hits   <= '0;
         him_n_new_hits   <= '0;
         him_read_row     <= 1'b0;
         him_row_to_read  <= '0;
      end else begin
         him_write_row <= hit_wr;
         him_read_row  <= rd_hs && (rd_cnt != '0);
         if (hit_wr) begin
            him_row_to_write <= sel_row;
            him_hit_info     <= $bits(him_hit_info)'(sel_hit);
            him_n_old_hits   <= sel_cnt;
            him_n_new_hits   <= MAXHITNBITS'(1);
         end
         if (rd_hs) him_row_to_read <= rd_row;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_busy       <= 1'b0;
         him_wait      <= 1'b0;
         clear_pend    <= 1'b0;
         rd_data_valid <= 1'b0;
         rd_data       <= '0;
         rd_nhits      <= '0;
         rd_nhits_pend <= '0;
      end else begin
         rd_data_valid <= 1'b0;
         if (rd_hs) begin
            rd_busy <= 1'b1;
            if (rd_cnt == '0) begin
               rd_data_valid <= 1'b1;
               rd_data       <= '0;
               rd_nhits      <= '0;
            end else begin
               him_wait      <= 1'b1;
               rd_nhits_pend <= rd_cnt;
            end
         end else if (him_wait && him_read_finished) begin
            him_wait      <= 1'b0;
            rd_data_valid <= 1'b1;
            rd_data       <= him_hit_info_read;
            rd_nhits      <= rd_nhits_pend;
         end else if (rd_data_valid) begin
            rd_busy <= 1'b0;
         end
         if (go_clear)
            clear_pend <= 1'b0;
         else if (state == ST_READ && event_clear)
            clear_pend <= 1'b1;
      end
   end

`ifdef HIM_SCHED_OVERFLOW_CNT_EN
   logic [15:0] ovf_cnt;
   logic        hit_drop;

   assign hit_drop = hit_hs && (sel_cnt == MAXHITNBITS'(ROW_CAP));

   always_ff @(posedge clk) begin
      if (reset || go_clear)
         ovf_cnt <= '0;
      else if (hit_drop && ovf_cnt != 16'hFFFF)
         ovf_cnt <= ovf_cnt + 16'd1;
   end

   assign overflow_count = ovf_cnt;
`else
   assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_him_scheduler.sv
// tb/tb_him_scheduler.sv - directed self-checking bench for him_scheduler
module tb_him_scheduler;
   localparam int NREQ = 4, ROWBITS = 10, HITBITS = 16, MAXHITNBITS = 3, DRAIN_CYCLES = 6;
   localparam int HW = HITBITS * 7;
`ifdef HIM_SCHED_OVERFLOW_CNT_EN
   localparam logic [15:0] OVF_EXP = 16'd1;
`else
   localparam logic [15:0] OVF_EXP = 16'd0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      reset;
   logic [NREQ-1:0]           hit_valid, hit_ready;
   logic [NREQ*ROWBITS-1:0]   hit_row;
   logic [NREQ*HITBITS-1:0]   hit_info;
   logic                      event_end, event_clear;
   logic                      him_write_row, him_read_row, him_read_finished;
   logic [ROWBITS-1:0]        him_row_to_write, him_row_to_read, rd_row;
   logic [HW-1:0]             him_hit_info, him_hit_info_read, rd_data;
   logic [MAXHITNBITS-1:0]    him_n_old_hits, him_n_new_hits, rd_nhits;
   logic                      rd_valid, rd_ready, rd_data_valid;
   logic [15:0]               overflow_count;
   logic [1:0]                phase;

   int total = 0;
   int bad = 0;
   int n, n_bad_phase, n_ready;
   logic [HW-1:0] d1, d2;

   him_scheduler #(
      .NREQ(NREQ), .ROWBITS(ROWBITS), .HITBITS(HITBITS),
      .MAXHITNBITS(MAXHITNBITS), .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clk(clk), .reset(reset),
      .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_row(hit_row), .hit_info(hit_info),
      .event_end(event_end), .event_clear(event_clear),
      .him_write_row(him_write_row), .him_row_to_write(him_row_to_write),
      .him_hit_info(him_hit_info), .him_n_old_hits(him_n_old_hits), .him_n_new_hits(him_n_new_hits),
      .him_read_row(him_read_row), .him_row_to_read(him_row_to_read),
      .him_read_finished(him_read_finished), .him_hit_info_read(him_hit_info_read),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_nhits(rd_nhits),
      .overflow_count(overflow_count), .phase(phase)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_hit(input int r, input int row, input logic [15:0] hit);
      hit_row[r*ROWBITS +: ROWBITS] = ROWBITS'(row);
      hit_info[r*HITBITS +: HITBITS] = hit;
   endtask

   task automatic wait_phase(input logic [1:0] target, input int bound, output int cnt);
      cnt = 0;
      while (phase !== target && cnt < bound) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; hit_valid = '0; hit_row = '0; hit_info = '0;
      event_end = 1'b0; event_clear = 1'b0; him_read_finished = 1'b0;
      him_hit_info_read = '0; rd_valid = 1'b0; rd_row = '0;
      d1 = 112'h1111_2222_3333_4444_5555_6666_7777;
      d2 = 112'hA0A0_B1B1_C2C2_D3D3_E4E4_F5F5_0606;
      repeat (3) tick();
      chk("rst_phase", phase, 0);
      chk("rst_wr", him_write_row, 0);
      chk("rst_rd", him_read_row, 0);
      chk("rst_dv", rd_data_valid, 0);
      chk("rst_ovf", overflow_count, 0);
      chk("rst_ready", {hit_ready, rd_ready}, 0);

      // Sweep: phase 0 for exactly 1024 cycles, nothing ready
      reset = 1'b0; hit_valid = 4'hF; rd_valid = 1'b1;
      n_bad_phase = 0; n_ready = 0;
      for (int i = 0; i < 1024; i++) begin
         #1;
         if (phase !== 2'd0) n_bad_phase++;
         if (hit_ready !== 4'h0 || rd_ready !== 1'b0) n_ready++;
         tick();
      end
      hit_valid = '0; rd_valid = 1'b0;
      chk("sweep_phase_not0", n_bad_phase, 0);
      chk("sweep_ready_seen", n_ready, 0);
      chk("fill_after_sweep", phase, 1);

      // Round robin between requesters 0 and 2
      set_hit(0, 5, 16'h00A5); set_hit(2, 9, 16'h02B9); hit_valid = 4'b0101;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_grant", hit_ready, (k % 2 == 0) ? 4'b0001 : 4'b0100);
         tick();
         if (k == 4) hit_valid = '0;
         chk("rr_wr_strobe", him_write_row, 1);
         chk("rr_wr_row", him_row_to_write, (k % 2 == 0) ? 5 : 9);
         chk("rr_n_old", him_n_old_hits, k / 2);
         chk("rr_hit", him_hit_info, (k % 2 == 0) ? 16'h00A5 : 16'h02B9);
         chk("rr_n_new", him_n_new_hits, 1);
      end
      tick();
      chk("rr_wr_one_cycle", him_write_row, 0);

      // Eight hits to row 3: seven writes then one drop
      hit_valid = 4'b0010;
      for (int k = 0; k < 8; k++) begin
         set_hit(1, 3, 16'h0C30 + 16'(k));
         #1;
         chk("ovf_grant", hit_ready, 4'b0010);
         tick();
         if (k == 7) hit_valid = '0;
         if (k < 7) begin
            chk("ovf_wr", him_write_row, 1);
            chk("ovf_n_old", him_n_old_hits, k);
            chk("ovf_hit", him_hit_info, 16'h0C30 + k);
         end else begin
            chk("ovf_drop_no_wr", him_write_row, 0);
         end
      end
      chk("ovf_count", overflow_count, OVF_EXP);

      // event_end with a simultaneous hit, then drain length
      set_hit(0, 11, 16'h0B0B); hit_valid = 4'b0001; event_end = 1'b1;
      tick();
      hit_valid = '0; event_end = 1'b0;
      chk("end_phase_drain", phase, 2);
      chk("end_hit_accepted", him_write_row, 1);
      chk("end_hit_row", him_row_to_write, 11);
      n_ready = 0; n = 0;
      while (phase !== 2'd3 && n < 20) begin
         if (rd_ready !== 1'b0) n_ready++;
         tick();
         n++;
      end
      chk("drain_len", n, DRAIN_CYCLES);
      chk("drain_ready_seen", n_ready, 0);

      // Readout of row 3 through the HIM
      rd_row = 10'd3; rd_valid = 1'b1;
      #1;
      chk("rd_ready_idle", rd_ready, 1);
      tick();
      rd_valid = 1'b0;
      chk("rd_him_strobe", him_read_row, 1);
      chk("rd_him_row", him_row_to_read, 3);
      chk("rd_ready_busy", rd_ready, 0);
      tick();
      chk("rd_him_strobe_1cyc", him_read_row, 0);
      chk("rd_dv_early", rd_data_valid, 0);
      him_hit_info_read = d1; him_read_finished = 1'b1;
      tick();
      him_read_finished = 1'b0;
      chk("rd_dv", rd_data_valid, 1);
      chk("rd_data", rd_data, d1);
      chk("rd_nhits_full", rd_nhits, 7);
      chk("rd_ready_at_dv", rd_ready, 0);
      tick();
      chk("rd_dv_pulse", rd_data_valid, 0);
      chk("rd_ready_back", rd_ready, 1);

      // Readout of empty row 4
      rd_row = 10'd4; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      chk("rd0_dv", rd_data_valid, 1);
      chk("rd0_nhits", rd_nhits, 0);
      chk("rd0_data", rd_data, 0);
      chk("rd0_no_him", him_read_row, 0);
      tick();
      chk("rd0_ready_back", rd_ready, 1);

      // event_clear while row 5 readout is outstanding
      rd_row = 10'd5; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0; event_clear = 1'b1;
      #1;
      chk("clr_rd_ready", rd_ready, 0);
      tick();
      event_clear = 1'b0;
      chk("clr_held", phase, 3);
      him_hit_info_read = d2; him_read_finished = 1'b1;
      tick();
      him_read_finished = 1'b0;
      chk("clr_dv", rd_data_valid, 1);
      chk("clr_nhits", rd_nhits, 3);
      chk("clr_data", rd_data, d2);
      chk("clr_phase_still_read", phase, 3);
      tick();
      chk("clr_entered", phase, 0);
      chk("clr_ovf_zero", overflow_count, 0);

      // Next event: row 3 reads back empty
      wait_phase(2'd1, 1100, n);
      chk("sweep2_len", n, 1024);
      event_end = 1'b1;
      tick();
      event_end = 1'b0;
      wait_phase(2'd3, 20, n);
      chk("drain2_len", n, DRAIN_CYCLES);
      rd_row = 10'd3; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      chk("reread_dv", rd_data_valid, 1);
      chk("reread_nhits", rd_nhits, 0);
      chk("reread_no_him", him_read_row, 0);
      tick();

      // Reset in the middle of FILL
      event_clear = 1'b1;
      tick();
      event_clear = 1'b0;
      wait_phase(2'd1, 1100, n);
      chk("sweep3_len", n, 1024);
      set_hit(0, 7, 16'h0707); hit_valid = 4'b0001;
      tick();
      tick();
      chk("mid_wr_active", him_write_row, 1);
      chk("mid_n_old", him_n_old_hits, 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_wr", him_write_row, 0);
      chk("mid_rst_phase", phase, 0);
      chk("mid_rst_ready", hit_ready, 0);
      hit_valid = '0; reset = 1'b0;
      wait_phase(2'd1, 1100, n);
      chk("sweep4_len", n, 1024);
      event_end = 1'b1;
      tick();
      event_end = 1'b0;
      wait_phase(2'd3, 20, n);
      chk("drain4_len", n, DRAIN_CYCLES);
      rd_row = 10'd7; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      chk("post_rst_dv", rd_data_valid, 1);
      chk("post_rst_nhits", rd_nhits, 0);
      chk("post_rst_no_him", him_read_row, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
